ps2_key_ctrl: RTL and testbench

- Sequences the PS/2 keyboard receive path: glitch-filters PS2C/PS2D, frames the 11-bit serial packets with a bit counter, checks start, parity and stop, and recovers from stalled frames by timeout.
- Interprets the E0 and F0 prefixes and emits one qualified key event per completed scan code.
- Produces game-level control strobes (flap, start) for the Flappy Bird game logic, running entirely in the clk_25 domain.

---
 rtl/ps2_key_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receive path: glitch filter, 11-bit frame checker with timeout,
// E0/F0 prefix decoding and Flappy Bird game strobes, all in the clk_25 domain.

module ps2_key_filt #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_25,
    input  logic rst,
    input  logic raw_i,
    output logic filt_o
);
    logic                s1_q, s2_q, filt_q;
    logic [FILT_LEN-1:0] sh_q;

    // Level only moves once the whole window agrees; anything mixed holds.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            sh_q   <= '1;
            filt_q <= 1'b1;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
            sh_q <= {sh_q[FILT_LEN-2:0], s2_q};
            if (&sh_q)       filt_q <= 1'b1;
            else if (~|sh_q) filt_q <= 1'b0;
        end
    end

    assign filt_o = filt_q;
endmodule

module ps2_key_ctrl #(
    parameter int         FILT_LEN  = 8,
    parameter int         TIMEOUT   = 5000,
    parameter logic [7:0] KEY_FLAP  = 8'h29,
    parameter logic [7:0] KEY_START = 8'h5A
) (
    input  logic       clk_25,
    input  logic       rst,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_ext,
    output logic       is_break,
    output logic       flap_pulse,
    output logic       flap_held,
    output logic       start_pulse,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic       c_f, d_f, c_prev_q, fall;
    state_t     state_q, state_d, cur;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       par_ok_q, par_ok_d;
    logic [TW-1:0] to_q, to_d;
    logic       timeout, err_d, acc_d, acc_q;
    logic       ext_pend_q, brk_pend_q;
    logic [7:0] scan_q;
    logic       cv_q, ext_q, brk_q, err_q;
    logic       flap_p_q, flap_h_q, start_p_q;

    ps2_key_filt #(.FILT_LEN(FILT_LEN)) u_filt_c (
        .clk_25(clk_25), .rst(rst), .raw_i(PS2C), .filt_o(c_f)
    );
    ps2_key_filt #(.FILT_LEN(FILT_LEN)) u_filt_d (
        .clk_25(clk_25), .rst(rst), .raw_i(PS2D), .filt_o(d_f)
    );

    assign fall    = c_prev_q & ~c_f;
    assign timeout = (state_q != IDLE) && (to_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            c_prev_q <= 1'b1;
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_ok_q <= 1'b0;
            to_q     <= '0;
            acc_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            c_prev_q <= c_f;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_ok_q <= par_ok_d;
            to_q     <= to_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_ok_d = par_ok_q;
        err_d    = 1'b0;
        acc_d    = 1'b0;
        to_d     = to_q;
        // A fall landing on the timeout cycle is handled as a fresh frame from IDLE.
        cur      = timeout ? IDLE : state_q;
        if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
        if (fall || state_q == IDLE) to_d = '0;
        else if (to_q != TW'(TIMEOUT - 1)) to_d = to_q + 1'b1;
        if (fall) begin
            case (cur)
                IDLE: begin
                    if (!d_f) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DATA: begin
                    shreg_d  = {d_f, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ^{shreg_q, d_f};
                    state_d  = STOP;
                end
                default: begin
                    if (d_f && par_ok_q) acc_d = 1'b1;
                    else                 err_d = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // shreg_q is stable in the accept cycle because the FSM is back in IDLE.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            scan_q     <= '0;
            cv_q       <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            cv_q <= 1'b0;
            if (err_d) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (acc_q) begin
                if (shreg_q == 8'hE0) begin
                    ext_pend_q <= 1'b1;
                end else if (shreg_q == 8'hF0) begin
                    brk_pend_q <= 1'b1;
                end else begin
                    cv_q       <= 1'b1;
                    scan_q     <= shreg_q;
                    ext_q      <= ext_pend_q;
                    brk_q      <= brk_pend_q;
                    ext_pend_q <= 1'b0;
                    brk_pend_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            flap_p_q  <= 1'b0;
            flap_h_q  <= 1'b0;
            start_p_q <= 1'b0;
        end else begin
            flap_p_q  <= 1'b0;
            start_p_q <= 1'b0;
            if (cv_q && !ext_q) begin
                if (scan_q == KEY_FLAP) begin
                    if (brk_q) begin
                        flap_h_q <= 1'b0;
                    end else if (!flap_h_q) begin
                        flap_p_q <= 1'b1;
                        flap_h_q <= 1'b1;
                    end
                end
                if (scan_q == KEY_START && !brk_q) start_p_q <= 1'b1;
            end
        end
    end

    assign scan_code   = scan_q;
    assign code_valid  = cv_q;
    assign is_ext      = ext_q;
    assign is_break    = brk_q;
    assign flap_pulse  = flap_p_q;
    assign flap_held   = flap_h_q;
    assign start_pulse = start_p_q;
    assign frame_err   = err_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: directed plan steps plus random byte streams,
// checked against a byte-level model of prefix decoding and game strobes.

module tb_ps2_key_ctrl;
    localparam int FILT_LEN = 8;
    localparam int HALF     = 20;

    logic       clk_25 = 1'b0;
    logic       rst    = 1'b1;
    logic       PS2C   = 1'b1;
    logic       PS2D   = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid, is_ext, is_break, flap_pulse, flap_held, start_pulse, frame_err;

    ps2_key_ctrl #(.FILT_LEN(FILT_LEN), .TIMEOUT(5000), .KEY_FLAP(8'h29), .KEY_START(8'h5A)) dut (
        .clk_25(clk_25), .rst(rst), .PS2C(PS2C), .PS2D(PS2D),
        .scan_code(scan_code), .code_valid(code_valid), .is_ext(is_ext), .is_break(is_break),
        .flap_pulse(flap_pulse), .flap_held(flap_held), .start_pulse(start_pulse),
        .frame_err(frame_err)
    );

    always #20 clk_25 = ~clk_25;

    int n_asrt = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk_25) cyc <= cyc + 1;

    // Observed side
    logic [9:0] obs_q[$];
    int o_err = 0, o_flap = 0, o_start = 0;
    int stop_cyc = 0, last_cv = 0, cv_lat = 0, fp_gap = 0, sp_gap = 0;

    always @(negedge clk_25) begin
        if (!rst) begin
            if (code_valid) begin
                obs_q.push_back({is_ext, is_break, scan_code});
                last_cv = cyc;
                cv_lat  = cyc - stop_cyc;
            end
            if (flap_pulse)  begin o_flap++;  fp_gap = cyc - last_cv; end
            if (start_pulse) begin o_start++; sp_gap = cyc - last_cv; end
            if (frame_err)   o_err++;
        end
    end

    // Byte-level reference model
    logic [9:0] exp_q[$];
    int  m_err = 0, m_flap = 0, m_start = 0;
    bit  m_ext = 0, m_brk = 0, m_held = 0;

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_err++;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            exp_q.push_back({m_ext, m_brk, b});
            if (!m_ext && b == 8'h29) begin
                if (m_brk) m_held = 0;
                else if (!m_held) begin m_flap++; m_held = 1; end
            end
            if (!m_ext && !m_brk && b == 8'h5A) m_start++;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_err"}, o_err, m_err);
        chk({tag, "_flap"}, o_flap, m_flap);
        chk({tag, "_start"}, o_start, m_start);
        chk({tag, "_held"}, {31'd0, flap_held}, {31'd0, m_held});
        chk({tag, "_nevt"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_evt"}, {22'd0, obs_q.pop_front()}, {22'd0, exp_q.pop_front()});
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_25);
    endtask

    // Sends the first n bits of a frame; glitch adds a 3-cycle low pulse on PS2C per bit.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int n, input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            PS2D = bits[i];
            wait_n(HALF / 2);
            if (glitch) begin
                PS2C = 1'b0; wait_n(3); PS2C = 1'b1;
            end
            wait_n(HALF / 2);
            PS2C = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_n(HALF);
            PS2C = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par);
        send_bits(b, bad_par, 11, 1'b0);
        PS2D = 1'b1;
        wait_n(40);
        model_byte(b, !bad_par);
    endtask

    logic [14:0] outs;
    assign outs = {scan_code, code_valid, is_ext, is_break, flap_pulse, flap_held, start_pulse, frame_err};

    initial begin
        logic [7:0] b;
        wait_n(5);
        chk("reset_outs", {17'd0, outs}, 32'd0);
        rst = 1'b0;
        wait_n(20);
        chk("idle_outs", {17'd0, outs}, 32'd0);

        // Single flap press
        send(8'h29, 0);
        chk("cv_lat_ok", (cv_lat >= FILT_LEN + 2 && cv_lat <= FILT_LEN + 8), 1);
        chk("flap_gap", fp_gap, 1);
        check_all("flap1");

        // Typematic repeats then release
        send(8'h29, 0); send(8'h29, 0); send(8'h29, 0);
        send(8'hF0, 0); send(8'h29, 0);
        check_all("typematic");

        // Extended break
        send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
        check_all("ext_brk");

        // Parity error then good start key
        send(8'h5A, 1);
        check_all("par_err");
        send(8'h5A, 0);
        chk("start_gap", sp_gap, 1);
        check_all("start");

        // Stalled frame recovers by timeout, prefix lost with it
        send(8'hF0, 0);
        send_bits(8'h29, 0, 5, 1'b0);
        wait_n(5100);
        model_byte(8'h00, 0);
        check_all("timeout");
        send(8'hF0, 0); send(8'h29, 0);
        check_all("after_to");

        // Glitches on PS2C while idle and mid-bit must not count
        for (int i = 0; i < 4; i++) begin
            PS2C = 1'b0; wait_n(3); PS2C = 1'b1; wait_n(15);
        end
        check_all("glitch_idle");
        send_bits(8'h5A, 0, 11, 1'b1);
        PS2D = 1'b1;
        wait_n(40);
        model_byte(8'h5A, 1);
        check_all("glitch_frame");

        // Reset in the middle of a frame
        send(8'h29, 0);
        check_all("pre_rst");
        send_bits(8'h29, 0, 4, 1'b0);
        rst = 1'b1;
        PS2D = 1'b1;
        wait_n(5);
        chk("rst_mid_outs", {17'd0, outs}, 32'd0);
        wait_n(20);
        rst = 1'b0;
        m_ext = 0; m_brk = 0; m_held = 0;
        wait_n(20);
        check_all("post_rst");
        send(8'h29, 0);
        check_all("post_rst_flap");

        // Random byte stream with prefixes and occasional parity errors
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: b = 8'h29;
                1: b = 8'h5A;
                2: b = 8'h75;
                default: b = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 3) == 0) send(8'hE0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) send(8'hF0, $urandom_range(0, 9) == 0);
            send(b, $urandom_range(0, 9) == 0);
            if (i % 10 == 9) check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
